aes_enc_iter_ctrl: RTL and testbench
====================================

Name: aes_enc_iter_ctrl

Overview:
- Iterative AES-128 encryption controller. Time-shares one `subbytes` instance across all rounds, one round per clock.
- Performs on-the-fly key expansion using four `aes_sbox` instances.
- Sits between the plaintext/key source and the ciphertext sink, with valid/ready handshakes on both sides.

Parameters:
- NUM_ROUNDS, 10, rounds executed. Legal range 1..10. 10 is FIPS-197 AES-128; other values are for reduced-round debug only.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext/key present
- in_ready  output  1  controller can accept a block
- in_key  input  128  cipher key; [127:120] = key byte 0
- in_data  input  128  plaintext; [127:120] = state byte 0, column-major (FIPS-197 input order)
- out_valid  output  1  ciphertext valid
- out_ready  input  1  sink accepts ciphertext
- out_data  output  128  ciphertext, same byte order as in_data
- busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, round counter=0, state register=0, round-key register=0.
  - in_ready=1 once reset deasserts; out_valid=0, out_data=0, busy=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: st <= in_data ^ in_key, rk <= in_key, rnd <= 1, go to ROUND.
  - in_data/in_key are sampled only on this edge.
- ROUND (in_ready=0), every cycle:
  - nrk = keyexp(rk, rcon[rnd]):
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
    - rcon = 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10
  - st <= MixColumns(ShiftRows(SubBytes(st))) ^ nrk. MixColumns is bypassed when rnd==NUM_ROUNDS.
  - rk <= nrk.
  - If rnd==NUM_ROUNDS go to DONE, else rnd <= rnd+1.
- DONE:
  - out_valid=1, out_data=st; both held stable until accepted.
  - On out_ready: go to IDLE; out_valid drops next cycle and out_data keeps its last value.
  - No new block is accepted in DONE, so there is no simultaneous input/output handshake.
- Latency: out_valid rises NUM_ROUNDS clock edges after the accepting edge. Throughput is one block per NUM_ROUNDS+2 cycles with out_ready held high.
- Datapath arithmetic:
  - ShiftRows: row r rotated left by r bytes.
  - MixColumns: GF(2^8) with xtime reduction polynomial 0x11b.
  - All datapath paths are purely combinational between registers.
- Boundary conditions:
  - in_valid dropping while not ready: no effect.
  - out_ready asserted outside DONE: ignored.
  - rst_n asserted mid-ROUND or mid-DONE: immediate return to reset values; the in-flight block is discarded with no partial output.
  - in_key changing during ROUND: no effect.
  - rnd never exceeds NUM_ROUNDS.

Optional Feature:
- AES_ABORT_EN defined:
  - Adds input port `abort` (1 bit).
  - `abort` sampled high in ROUND or DONE forces IDLE on the next edge.
  - out_valid is deasserted on that edge; st/rk are cleared to 0; rnd is cleared to 0.
  - In IDLE, `abort` is ignored. If in_valid and abort are both high in IDLE, the block is accepted.
- Not defined: no `abort` port; a block can only leave via the DONE handshake or rst_n.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after the accepting edge.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: all-zero key and pt, out_ready held low 5 cycles after out_valid -> out_data stable at 66e94bd4ef8a2c3b884cfa59ca342b2e, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: two App. B blocks with in_valid and out_ready held high -> second acceptance occurs exactly 12 cycles after the first, and both outputs are correct.
- Reset mid-operation: rst_n low during round 5 -> all outputs reach reset values immediately; the next App. C.1 block completes correctly.
- AES_ABORT_EN: abort pulse in round 3 -> IDLE next edge, no out_valid, busy=0; the following block encrypts correctly.

Source files
------------

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryption controller.
// One round per clock. A single 16-lane SubBytes stage is shared by all rounds,
// and four key S-boxes expand the next round key on the fly.
// Optional build macro: AES_ABORT_EN adds an 'abort' input that cancels an
// in-flight block and returns the controller to IDLE.
module aes_enc_iter_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // GF(2^8) multiply, reduction polynomial 0x11b
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // AES S-box: multiplicative inverse as a^254, followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(a, a);          // a^2
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gf_mul(sq, sq);    // a^(2^k)
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t       state_q,     state_d;
    logic [3:0]   rnd_q,       rnd_d;
    logic [127:0] st_q,        st_d;
    logic [127:0] rk_q,        rk_d;
    logic         in_ready_q,  in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q,  out_data_d;
    logic         busy_q,      busy_d;

    logic [127:0] sb_out;
    logic [127:0] sr_out;
    logic [127:0] mc_out;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [127:0] nrk;
    logic [127:0] round_out;

    // Shared SubBytes stage: 16 S-box lanes over the current state
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_subbytes
            assign sb_out[127-8*gi -: 8] = sbox(st_q[127-8*gi -: 8]);
        end
    endgenerate

    // ShiftRows: byte (row r, col c) takes the byte from column (c+r) mod 4
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shiftrows
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = 4 * ((C + R) % 4) + R;
            assign sr_out[127-8*gi -: 8] = sb_out[127-8*SRC -: 8];
        end
    endgenerate

    // MixColumns, one column per generate lane
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mixcol
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr_out[127-32*gi -: 8];
            assign a1 = sr_out[119-32*gi -: 8];
            assign a2 = sr_out[111-32*gi -: 8];
            assign a3 = sr_out[103-32*gi -: 8];
            assign mc_out[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc_out[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc_out[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc_out[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // Key expansion: four S-boxes on RotWord(w3)
    assign rot_w3 = {rk_q[23:0], rk_q[31:24]};
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign sub_w3[31-8*gi -: 8] = sbox(rot_w3[31-8*gi -: 8]);
        end
    endgenerate

    assign nrk[127:96] = rk_q[127:96] ^ sub_w3 ^ {rcon(rnd_q), 24'h0};
    assign nrk[95:64]  = rk_q[95:64]  ^ nrk[127:96];
    assign nrk[63:32]  = rk_q[63:32]  ^ nrk[95:64];
    assign nrk[31:0]   = rk_q[31:0]   ^ nrk[63:32];

    // The final round skips MixColumns
    assign round_out = ((rnd_q == LAST_RND) ? sr_out : mc_out) ^ nrk;

    // Next-state and registered-output logic for the IDLE/ROUND/DONE controller
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        rk_d        = rk_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d       = in_data ^ in_key;
                    rk_d       = in_key;
                    rnd_d      = 4'd1;
                    state_d    = S_ROUND;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_ROUND: begin
                st_d = round_out;
                rk_d = nrk;
                if (rnd_q == LAST_RND) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = round_out;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    rnd_d       = 4'd0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rnd_d       = 4'd0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
`ifdef AES_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            rnd_d       = 4'd0;
            st_d        = 128'h0;
            rk_d        = 128'h0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
        end
`endif
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rnd_q       <= 4'd0;
            st_q        <= 128'h0;
            rk_q        <= 128'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 128'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// Self-checking bench for aes_enc_iter_ctrl: FIPS-197 vectors, back-pressure,
// back-to-back, reset mid-block, optional abort, and randomized blocks checked
// against a byte-array AES reference model.
module tb_aes_enc_iter_ctrl;

    localparam int NR = 10;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc[$];
    logic [127:0] out_q[$];
    logic [7:0] sbox_t [256];

    aes_enc_iter_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AES_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and handshake monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
        if (rst_n && out_valid && out_ready) out_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt, input int nr);
        logic [31:0]  w [44];
        logic [7:0]   rc [11];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [127:0] res;
        rc[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rc[j] = gmul(rc[j-1], 8'h02);
        for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32*i));
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (120 - 8*i)) ^ 8'(key >> (120 - 8*i));
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r != nr) begin
                    s[4*c+0] = gmul(t[4*c],8'h2) ^ gmul(t[4*c+1],8'h3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h2) ^ gmul(t[4*c+2],8'h3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h2) ^ gmul(t[4*c+3],8'h3);
                    s[4*c+3] = gmul(t[4*c],8'h3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h2);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= 8'(w[4*r + i/4] >> (24 - 8*(i%4)));
        end
        res = 0;
        for (int i = 0; i < 16; i++) res = (res << 8) | 128'(s[i]);
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block: present, count latency, hold out_ready low 'hold' cycles, accept
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp, input int hold, input bit noisy);
        int n;
        in_key = key; in_data = pt; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("idle_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept_busy", 128'(busy), 128'd1);
        check("accept_in_ready", 128'(in_ready), 128'd0);
        n = 0;
        while (!out_valid && n < 60) begin
            if (noisy) begin
                in_key = rand128(); in_data = rand128();
                in_valid = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("latency", 128'(n), 128'(NR));
        check("ciphertext", out_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 128'(out_valid), 128'd1);
            check("hold_data", out_data, exp);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 128'(out_valid), 128'd0);
        check("post_in_ready", 128'(in_ready), 128'd1);
        check("post_busy", 128'(busy), 128'd0);
        check("post_data", out_data, exp);
        $display("block key=%h pt=%h ct=%h lat=%0d hold=%0d", key, pt, out_data, n, hold);
    endtask

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    initial begin
        int n;
        logic [127:0] k, p;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_data = '0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 vectors and back-pressure
        run_block(KB, PB, CB, 0, 1'b0);
        run_block(KC, PC, CC, 1, 1'b0);
        run_block(128'h0, 128'h0, CZ, 5, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        acc_cyc.delete(); out_q.delete();
        in_key = KB; in_data = PB; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (acc_cyc.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        n = 0;
        while (out_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        check("b2b_accepts", 128'(acc_cyc.size()), 128'd2);
        check("b2b_outputs", 128'(out_q.size()), 128'd2);
        if (acc_cyc.size() >= 2) check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NR + 2));
        if (out_q.size() >= 2) begin
            check("b2b_ct0", out_q[0], CB);
            check("b2b_ct1", out_q[1], CB);
        end
        $display("back-to-back accepts=%0d outputs=%0d", acc_cyc.size(), out_q.size());
        @(posedge clk); #1;

        // Reset during round 5
        in_key = KB; in_data = PB; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_q.delete();
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_output", 128'(out_valid), 128'd0);
        $display("reset mid-round done");
        run_block(KC, PC, CC, 0, 1'b0);

`ifdef AES_ABORT_EN
        // Abort during round 3
        in_key = KB; in_data = PB; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid) n++; end
        check("abort_no_output", 128'(n), 128'd0);
        $display("abort in round 3 done");
        run_block(KB, PB, CB, 0, 1'b0);
`endif

        // Randomized blocks with noisy inputs during the rounds
        for (int b = 0; b < 20; b++) begin
            k = rand128(); p = rand128();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_block(k, p, aes_ref(k, p, NR), $urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
